// File: rtl/serial_pkg.sv
// Shared types and helpers for the bit-serial operand transmitter.
package serial_pkg;

  typedef enum logic {IDLE, SEND} ser_state_t;

  // Word length minus one, limited to the widest word the datapath holds.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned w);
    return (len > w - 1) ? w - 1 : len;
  endfunction

endpackage

// File: rtl/serial_operand_tx_if.sv
// Parallel operand handshake plus serial vld/a/b/last stream.
// SERIAL_TX_BUBBLE_EN adds the bubble input used to punch holes in the stream.
interface serial_operand_tx_if #(parameter int W = 8);
  localparam int LW = $clog2(W);

  logic          up_vld;
  logic          up_rdy;
  logic [W-1:0]  up_a;
  logic [W-1:0]  up_b;
  logic [LW-1:0] up_len_m1;
  logic          vld;
  logic          a;
  logic          b;
  logic          last;
`ifdef SERIAL_TX_BUBBLE_EN
  logic          bubble;

  modport master (output up_vld, up_a, up_b, up_len_m1, bubble,
                  input  up_rdy, vld, a, b, last);
  modport slave  (input  up_vld, up_a, up_b, up_len_m1, bubble,
                  output up_rdy, vld, a, b, last);
`else
  modport master (output up_vld, up_a, up_b, up_len_m1,
                  input  up_rdy, vld, a, b, last);
  modport slave  (input  up_vld, up_a, up_b, up_len_m1,
                  output up_rdy, vld, a, b, last);
`endif
endinterface

// File: rtl/serial_shift_reg.sv
// Parallel-load right shifter exposing its LSB; one per serialised operand.
module serial_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] d_i,
  output logic         bit0_o
);

  logic [W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (load_i)       data_d = d_i;
    else if (shift_i) data_d = {1'b0, data_q[W-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign bit0_o = data_q[0];

endmodule

// File: rtl/serial_operand_tx.sv
// Bit-serial operand transmitter: parallel pair in, LSB-first vld/a/b/last out.
// SERIAL_TX_BUBBLE_EN enables the bubble input that inserts vld=0 holes mid-word.
module serial_operand_tx
  import serial_pkg::*;
#(
  parameter int W = 8
) (
  input logic                 clk,
  input logic                 rst,
  serial_operand_tx_if.slave  bus
);

  localparam int LW = $clog2(W);

  ser_state_t    state_q, state_d;
  logic [LW-1:0] rem_q, rem_d;
  logic          vld_q, vld_d;
  logic          a_q, a_d;
  logic          b_q, b_d;
  logic          last_q, last_d;
  logic          up_rdy, accept, beat_done, load, shift, bubble_w;
  logic          sh_a, sh_b;
  logic [LW-1:0] len_c;

`ifdef SERIAL_TX_BUBBLE_EN
  assign bubble_w = bus.bubble;
`else
  assign bubble_w = 1'b0;
`endif

  assign len_c     = LW'(clamp_len(32'(bus.up_len_m1), W));
  assign beat_done = vld_q & last_q;
  assign up_rdy    = (state_q == IDLE) | beat_done;
  assign accept    = bus.up_vld & up_rdy;

  // Bit 0 goes straight to the output register; the shifters keep the rest.
  serial_shift_reg #(.W(W)) u_sh_a (
    .clk(clk), .rst(rst), .load_i(load), .shift_i(shift),
    .d_i({1'b0, bus.up_a[W-1:1]}), .bit0_o(sh_a)
  );

  serial_shift_reg #(.W(W)) u_sh_b (
    .clk(clk), .rst(rst), .load_i(load), .shift_i(shift),
    .d_i({1'b0, bus.up_b[W-1:1]}), .bit0_o(sh_b)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    vld_d   = 1'b0;
    a_d     = 1'b0;
    b_d     = 1'b0;
    last_d  = 1'b0;
    shift   = 1'b0;
    load    = accept;

    case (state_q)
      IDLE: ;
      SEND: begin
        if (beat_done) begin
          state_d = IDLE;
        end else if (!bubble_w) begin
          // rem_q counts beats still owed after the one on the wire
          vld_d  = 1'b1;
          a_d    = sh_a;
          b_d    = sh_b;
          last_d = (rem_q == LW'(1));
          rem_d  = rem_q - LW'(1);
          shift  = 1'b1;
        end
      end
    endcase

    if (load) begin
      state_d = SEND;
      vld_d   = 1'b1;
      a_d     = bus.up_a[0];
      b_d     = bus.up_b[0];
      last_d  = (len_c == '0);
      rem_d   = len_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      vld_q   <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      vld_q   <= vld_d;
      a_q     <= a_d;
      b_q     <= b_d;
      last_q  <= last_d;
    end
  end

  assign bus.up_rdy = up_rdy;
  assign bus.vld    = vld_q;
  assign bus.a      = a_q;
  assign bus.b      = b_q;
  assign bus.last   = last_q;

endmodule

// File: tb/tb_serial_operand_tx.sv
// Directed bench for serial_operand_tx (W=8 and a W=6 instance for length clamping).
module tb_serial_operand_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_operand_tx_if #(.W(8)) bus8();
  serial_operand_tx_if #(.W(6)) bus6();

  serial_operand_tx #(.W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_operand_tx #(.W(6)) dut6 (.clk(clk), .rst(rst), .bus(bus6));

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] wa, wb, wa2, wb2, sum;
  logic       cy;
  logic [5:0] w6a, w6b;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat8(input string tag, input logic v, input logic ea, input logic eb,
                       input logic el, input logic er);
    chk({tag, ".vld"},    8'(bus8.vld),    8'(v));
    chk({tag, ".a"},      8'(bus8.a),      8'(ea));
    chk({tag, ".b"},      8'(bus8.b),      8'(eb));
    chk({tag, ".last"},   8'(bus8.last),   8'(el));
    chk({tag, ".up_rdy"}, 8'(bus8.up_rdy), 8'(er));
  endtask

  task automatic put8(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] l);
    bus8.up_vld    = v;
    bus8.up_a      = a;
    bus8.up_b      = b;
    bus8.up_len_m1 = l;
  endtask

  initial begin
    rst = 1'b1;
    put8(1'b0, 8'h00, 8'h00, 3'd0);
    bus6.up_vld = 1'b0; bus6.up_a = '0; bus6.up_b = '0; bus6.up_len_m1 = '0;
`ifdef SERIAL_TX_BUBBLE_EN
    bus8.bubble = 1'b0;
    bus6.bubble = 1'b0;
`endif
    tick; tick;
    rst = 1'b0;
    beat8("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // 0x0F + 0x01 over 8 beats, folded through a bench serial adder
    wa = 8'h0F; wb = 8'h01; sum = '0; cy = 1'b0;
    put8(1'b1, wa, wb, 3'd7);
    tick;
    put8(1'b0, 8'h00, 8'h00, 3'd0);
    for (int i = 0; i < 8; i++) begin
      beat8("w8", 1'b1, wa[i], wb[i], i == 7, i == 7);
      sum[i] = bus8.a ^ bus8.b ^ cy;
      cy     = (bus8.a & bus8.b) | (cy & (bus8.a ^ bus8.b));
      tick;
    end
    chk("w8.sum", sum, 8'h10);
    beat8("w8.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // length 1
    put8(1'b1, 8'hFF, 8'h00, 3'd0);
    tick;
    put8(1'b0, 8'h00, 8'h00, 3'd0);
    beat8("len1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    tick;
    beat8("len1.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // back-to-back 4-bit words; second pair presented early and ignored until last
    wa = 8'hAA; wb = 8'h55; wa2 = 8'h01; wb2 = 8'h01;
    put8(1'b1, wa, wb, 3'd3);
    tick;
    put8(1'b1, wa2, wb2, 3'd3);
    for (int i = 0; i < 8; i++) begin
      if (i < 4) beat8("b2b", 1'b1, wa[i], wb[i], i == 3, i == 3);
      else       beat8("b2b", 1'b1, wa2[i-4], wb2[i-4], i == 7, i == 7);
      if (i == 4) put8(1'b0, 8'h00, 8'h00, 3'd0);
      tick;
    end
    beat8("b2b.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // reset during beat 3 abandons the word
    wa = 8'hC3; wb = 8'h3C;
    put8(1'b1, wa, wb, 3'd7);
    tick;
    put8(1'b0, 8'h00, 8'h00, 3'd0);
    beat8("rst.b1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick;
    beat8("rst.b2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick;
    beat8("rst.b3", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    beat8("rst.cut", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick;
    beat8("rst.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    wa = 8'h5A; wb = 8'h0F;
    put8(1'b1, wa, wb, 3'd4);
    tick;
    put8(1'b0, 8'h00, 8'h00, 3'd0);
    for (int i = 0; i < 5; i++) begin
      beat8("fresh", 1'b1, wa[i], wb[i], i == 4, i == 4);
      tick;
    end
    beat8("fresh.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // W=6 instance: len_m1=7 clamps to 6 beats
    w6a = 6'h2D; w6b = 6'h12;
    bus6.up_vld = 1'b1; bus6.up_a = w6a; bus6.up_b = w6b; bus6.up_len_m1 = 3'd7;
    tick;
    bus6.up_vld = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("clamp.vld",  8'(bus6.vld),  8'h01);
      chk("clamp.a",    8'(bus6.a),    8'(w6a[i]));
      chk("clamp.b",    8'(bus6.b),    8'(w6b[i]));
      chk("clamp.last", 8'(bus6.last), 8'(i == 5));
      tick;
    end
    chk("clamp.after.vld",    8'(bus6.vld),    8'h00);
    chk("clamp.after.up_rdy", 8'(bus6.up_rdy), 8'h01);

`ifdef SERIAL_TX_BUBBLE_EN
    // two holes after beat 2, then the remaining bits unchanged
    wa = 8'h0F; wb = 8'h01;
    put8(1'b1, wa, wb, 3'd7);
    tick;
    put8(1'b0, 8'h00, 8'h00, 3'd0);
    beat8("bub.b1", 1'b1, wa[0], wb[0], 1'b0, 1'b0);
    tick;
    beat8("bub.b2", 1'b1, wa[1], wb[1], 1'b0, 1'b0);
    bus8.bubble = 1'b1;
    tick;
    beat8("bub.hole1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    beat8("bub.hole2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus8.bubble = 1'b0;
    tick;
    for (int i = 2; i < 8; i++) begin
      beat8("bub.rest", 1'b1, wa[i], wb[i], i == 7, i == 7);
      tick;
    end
    beat8("bub.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
